// File: rtl/freq_bcd_conv.sv
// freq_bcd_conv: sequential double-dabble binary-to-BCD converter with leading-zero blanking and saturation
module freq_bcd_conv #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_vld,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_W);
    localparam int FS_I = 10**DIGITS - 1;
    localparam logic [DATA_W:0] FS = FS_I[DATA_W:0];
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state, nxt;
    logic force_cnv, ovf_p, start, z;
    logic [DATA_W-1:0] last_val, sreg;
    logic [4*DIGITS-1:0] acc, acc_adj;
    logic [DIGITS-1:0] blank_nx;
    logic [CW-1:0] cnt;

    assign start = force_cnv || (bin_in != last_val);
    assign busy = (state == LOAD) || (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = SHIFT;
            SHIFT:   nxt = (cnt == CNT_LAST) ? DONE : SHIFT;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Per-digit +3 correction, no carry between digits
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++)
            acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end

    // Digit i blanks only when it and every more-significant digit are zero
    always_comb begin
        blank_nx = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z = z && (acc[4*i +: 4] == 4'd0);
            blank_nx[i] = z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_cnv <= 1'b1;
            last_val  <= '0;
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf_p     <= 1'b0;
            bcd_out   <= '0;
            blank     <= {{(DIGITS-1){1'b1}}, 1'b0};
            ovf       <= 1'b0;
            bcd_vld   <= 1'b0;
        end else begin
            bcd_vld <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    last_val  <= bin_in;
                    sreg      <= bin_in;
                    force_cnv <= 1'b0;
                end
                LOAD: begin
                    sreg  <= ({1'b0, sreg} > FS) ? FS[DATA_W-1:0] : sreg;
                    ovf_p <= {1'b0, sreg} > FS;
                    acc   <= '0;
                    cnt   <= '0;
                end
                SHIFT: begin
                    {acc, sreg} <= {acc_adj, sreg} << 1;
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    bcd_out <= acc;
                    blank   <= blank_nx;
                    ovf     <= ovf_p;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_bcd_conv.sv
// tb_freq_bcd_conv: randomized self-checking bench against an arithmetic BCD reference model
module tb_freq_bcd_conv;
    logic clk = 1'b0;
    logic rst_n;
    logic [19:0] bin_in;
    logic [23:0] bcd_out;
    logic bcd_vld;
    logic [5:0] blank;
    logic ovf;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] exp_bcd;
    logic [5:0] exp_blank;
    logic exp_ovf;

    always #5 clk = ~clk;

    freq_bcd_conv dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bcd_out(bcd_out),
        .bcd_vld(bcd_vld), .blank(blank), .ovf(ovf), .busy(busy)
    );

    function automatic int sat(input logic [19:0] v);
        return (int'(v) > 999999) ? 999999 : int'(v);
    endfunction

    function automatic logic [23:0] ref_bcd(input logic [19:0] v);
        logic [23:0] r;
        int s;
        s = sat(v);
        for (int d = 0; d < 6; d++) r[4*d +: 4] = 4'((s / (10**d)) % 10);
        return r;
    endfunction

    function automatic logic [5:0] ref_blank(input logic [19:0] v);
        logic [5:0] b;
        b = '0;
        for (int i = 1; i < 6; i++) b[i] = sat(v) < 10**i;
        return b;
    endfunction

    task automatic test_convert(input logic [19:0] v);
        int n;
        n = 0;
        bin_in = v;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL busy_load v=%0d: got %b expected 1", v, busy); end
            end
            if (n == 10) begin
                n_cmp++;
                if (bcd_out !== exp_bcd) begin n_err++; $display("FAIL hold v=%0d: got %h expected %h", v, bcd_out, exp_bcd); end
            end
        end while (!bcd_vld && n < 40);
        n_cmp++;
        if (n !== 23) begin n_err++; $display("FAIL latency v=%0d: got %0d expected 23", v, n); end
        exp_bcd = ref_bcd(v);
        exp_blank = ref_blank(v);
        exp_ovf = int'(v) > 999999;
        n_cmp += 4;
        if (bcd_out !== exp_bcd) begin n_err++; $display("FAIL bcd v=%0d: got %h expected %h", v, bcd_out, exp_bcd); end
        if (blank !== exp_blank) begin n_err++; $display("FAIL blank v=%0d: got %b expected %b", v, blank, exp_blank); end
        if (ovf !== exp_ovf) begin n_err++; $display("FAIL ovf v=%0d: got %b expected %b", v, ovf, exp_ovf); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_done v=%0d: got %b expected 0", v, busy); end
        @(negedge clk);
        n_cmp++;
        if (bcd_vld !== 1'b0) begin n_err++; $display("FAIL pulse v=%0d: got %b expected 0", v, bcd_vld); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (bcd_out !== 24'h0) begin n_err++; $display("FAIL rst_bcd: got %h expected 000000", bcd_out); end
        if (bcd_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b expected 0", bcd_vld); end
        if (blank !== 6'b111110) begin n_err++; $display("FAIL rst_blank: got %b expected 111110", blank); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        exp_bcd = '0;
        exp_blank = 6'b111110;
        exp_ovf = 1'b0;
        rst_n = 1'b1;
        test_convert(20'd0);
    endtask

    task automatic test_directed;
        logic [19:0] vals [9] = '{20'd123456, 20'd500, 20'd50000, 20'hFFFFF, 20'd7,
                                  20'd999999, 20'd1000000, 20'd1, 20'd123456};
        int seen;
        foreach (vals[i]) test_convert(vals[i]);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bcd_vld) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL hold_no_pulse: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        int n;
        test_convert(20'd100);
        n = 0;
        bin_in = 20'd111111;
        do begin
            @(negedge clk);
            n++;
            if (n == 6) bin_in = 20'd222222;
            if (n == 11) bin_in = 20'd333333;
            if (!bcd_vld) begin
                n_cmp++;
                if (bcd_out !== exp_bcd) begin n_err++; $display("FAIL b2b_hold n=%0d: got %h expected %h", n, bcd_out, exp_bcd); end
            end
        end while (!bcd_vld && n < 40);
        n_cmp += 2;
        if (n !== 23) begin n_err++; $display("FAIL b2b_lat1: got %0d expected 23", n); end
        if (bcd_out !== 24'h111111) begin n_err++; $display("FAIL b2b_first: got %h expected 111111", bcd_out); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bcd_vld && n < 40);
        n_cmp += 3;
        if (n !== 23) begin n_err++; $display("FAIL b2b_lat2: got %0d expected 23", n); end
        if (bcd_out !== 24'h333333) begin n_err++; $display("FAIL b2b_second: got %h expected 333333", bcd_out); end
        if (blank !== 6'b000000) begin n_err++; $display("FAIL b2b_blank: got %b expected 000000", blank); end
        exp_bcd = 24'h333333;
        exp_blank = 6'b000000;
        exp_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_same_value;
        int seen;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bcd_vld || busy) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL same_value: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid;
        bin_in = 20'd654321;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (bcd_out !== 24'h0) begin n_err++; $display("FAIL mid_bcd: got %h expected 000000", bcd_out); end
        if (bcd_vld !== 1'b0) begin n_err++; $display("FAIL mid_vld: got %b expected 0", bcd_vld); end
        if (blank !== 6'b111110) begin n_err++; $display("FAIL mid_blank: got %b expected 111110", blank); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL mid_ovf: got %b expected 0", ovf); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
        exp_bcd = '0;
        exp_blank = 6'b111110;
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_convert(20'd654321);
    endtask

    task automatic test_random;
        logic [19:0] v;
        repeat (24) begin
            v = 20'($urandom_range(0, 20'hFFFFF) >> $urandom_range(0, 19));
            if (v == bin_in) v = v ^ 20'd1;
            test_convert(v);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_same_value;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
